// File: rtl/dc_mem_bridge.sv
// dc_mem_bridge
//   Turns data-cache memory-port requests into DWORD beats on a 32-bit bus.
//   A 128-bit tile request becomes four beats and a DWORD request becomes one.
//   Read data and a UMEM_OK_* status code go back to the cache.
//   Illegal ops, bus FAULTs and per-beat timeouts are reported as FAULT.
// Ports
//   clock, reset (async, active-low)
//   memInAddr/memInData/memInOE/memInWR/memInOp : request from the cache
//   memOutData/memOutOK                         : response to the cache
//   busAddr/busDataOut/busOE/busWR              : bus request (all registered)
//   busDataIn/busOK                             : bus response
module dc_mem_bridge #(
  parameter int TIMEOUT = 255
) (
  input  logic         clock,
  input  logic         reset,
  input  logic [31:0]  memInAddr,
  input  logic [127:0] memInData,
  input  logic         memInOE,
  input  logic         memInWR,
  input  logic [4:0]   memInOp,
  output logic [127:0] memOutData,
  output logic [1:0]   memOutOK,
  output logic [31:0]  busAddr,
  output logic [31:0]  busDataOut,
  input  logic [31:0]  busDataIn,
  output logic         busOE,
  output logic         busWR,
  input  logic [1:0]   busOK
);

  localparam logic [1:0] OK_READY = 2'd0;
  localparam logic [1:0] OK_OK    = 2'd1;
  localparam logic [1:0] OK_HOLD  = 2'd2;
  localparam logic [1:0] OK_FAULT = 2'd3;

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_BEAT = 3'd1;
  localparam logic [2:0] S_RESP = 3'd2;
  localparam logic [2:0] S_FLT  = 3'd3;
  localparam logic [2:0] S_COOL = 3'd4;

  // The counter counts the wait cycles already seen in this beat.
  // When it reaches TIMEOUT-1 and yet another wait cycle arrives,
  // that cycle is the TIMEOUT-th consecutive wait.
  localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

  logic [2:0] state;
  logic [1:0] beat;
  logic [7:0] waitCnt;
  logic       isTile;
  logic       isWr;
  logic [1:0] nextBeat;
  logic       reqTile;
  logic       reqDword;

  assign nextBeat = beat + 2'd1;
  assign reqTile  = (memInOp == 5'd1);
  assign reqDword = (memInOp == 5'd2);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state      <= S_IDLE;
      beat       <= 2'd0;
      waitCnt    <= 8'd0;
      isTile     <= 1'b0;
      isWr       <= 1'b0;
      memOutData <= '0;
      memOutOK   <= OK_READY;
      busAddr    <= '0;
      busDataOut <= '0;
      busOE      <= 1'b0;
      busWR      <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (memInOE || memInWR) begin
            // WR wins over OE, so a read-modify-write is handled as a write.
            isWr       <= memInWR;
            beat       <= 2'd0;
            waitCnt    <= 8'd0;
            memOutData <= '0;
            if (reqTile || reqDword) begin
              isTile   <= reqTile;
              state    <= S_BEAT;
              memOutOK <= OK_HOLD;
              busOE    <= !memInWR;
              busWR    <= memInWR;
              busAddr  <= reqTile ? {memInAddr[31:4], 4'b0000}
                                  : {memInAddr[31:2], 2'b00};
              // On a write, the data register doubles as the store buffer.
              // It then holds the written value as the response data.
              if (memInWR) begin
                busDataOut <= memInData[31:0];
                memOutData <= reqTile ? memInData : {96'd0, memInData[31:0]};
              end else begin
                busDataOut <= 32'd0;
              end
            end else begin
              state    <= S_FLT;
              memOutOK <= OK_FAULT;
            end
          end
        end

        S_BEAT: begin
          if (busOK == OK_OK) begin
            if (!isWr) memOutData[{beat, 5'b00000} +: 32] <= busDataIn;
            waitCnt <= 8'd0;
            if (!isTile || beat == 2'd3) begin
              state    <= S_RESP;
              memOutOK <= OK_OK;
              busOE    <= 1'b0;
              busWR    <= 1'b0;
            end else begin
              beat         <= nextBeat;
              busAddr[3:2] <= nextBeat;
              busDataOut   <= memOutData[{nextBeat, 5'b00000} +: 32];
            end
          end else if (busOK == OK_FAULT || waitCnt == TO_LAST) begin
            state    <= S_FLT;
            memOutOK <= OK_FAULT;
            busOE    <= 1'b0;
            busWR    <= 1'b0;
            waitCnt  <= 8'd0;
          end else begin
            waitCnt <= waitCnt + 8'd1;
          end
        end

        S_RESP, S_FLT: begin
          state    <= S_COOL;
          memOutOK <= OK_READY;
        end

        // COOL holds the cache off for one cycle between responses.
        default: begin
          state    <= S_IDLE;
          memOutOK <= OK_READY;
          busOE    <= 1'b0;
          busWR    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dc_mem_bridge.sv
// Directed bench for dc_mem_bridge.
// Each test presents a request in cycle N and then steps one cycle at a time.
// It checks the bus strobes, bus address, bus data, status and read data.
// The expected values are computed by hand.
module tb_dc_mem_bridge;

  logic         clock = 1'b0;
  logic         reset = 1'b0;
  logic [31:0]  memInAddr = '0;
  logic [127:0] memInData = '0;
  logic         memInOE = 1'b0;
  logic         memInWR = 1'b0;
  logic [4:0]   memInOp = '0;
  logic [127:0] memOutData;
  logic [1:0]   memOutOK;
  logic [31:0]  busAddr;
  logic [31:0]  busDataOut;
  logic [31:0]  busDataIn = '0;
  logic         busOE;
  logic         busWR;
  logic [1:0]   busOK = 2'd0;

  int checks = 0;
  int errors = 0;

  dc_mem_bridge #(.TIMEOUT(4)) dut (
    .clock(clock), .reset(reset),
    .memInAddr(memInAddr), .memInData(memInData),
    .memInOE(memInOE), .memInWR(memInWR), .memInOp(memInOp),
    .memOutData(memOutData), .memOutOK(memOutOK),
    .busAddr(busAddr), .busDataOut(busDataOut), .busDataIn(busDataIn),
    .busOE(busOE), .busWR(busWR), .busOK(busOK)
  );

  always #5 clock = ~clock;

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic req(input logic [31:0] a, input logic [127:0] d,
                     input logic oe, input logic wr, input logic [4:0] op);
    memInAddr = a; memInData = d; memInOE = oe; memInWR = wr; memInOp = op;
  endtask

  task automatic drop();
    memInOE = 1'b0; memInWR = 1'b0;
  endtask

  initial begin
    // reset state
    #12;
    chk("rst_ok", memOutOK, 2'd0);
    chk("rst_oe", busOE, 1'b0);
    chk("rst_wr", busWR, 1'b0);
    chk("rst_addr", busAddr, 32'd0);
    chk("rst_dout", busDataOut, 32'd0);
    chk("rst_data", memOutData, 128'd0);
    reset = 1'b1;
    step();

    // tile read, zero-wait
    req(32'h0000_1230, '0, 1'b1, 1'b0, 5'd1);
    step(); drop();                                   // N+1
    chk("tr_oe1", busOE, 1'b1);
    chk("tr_hold", memOutOK, 2'd2);
    chk("tr_a0", busAddr, 32'h1230);
    busOK = 2'd1; busDataIn = 32'h1111_1111;
    step(); chk("tr_a1", busAddr, 32'h1234); busDataIn = 32'h2222_2222;
    step(); chk("tr_a2", busAddr, 32'h1238); busDataIn = 32'h3333_3333;
    step(); chk("tr_a3", busAddr, 32'h123C); busDataIn = 32'h4444_4444;
    step(); busOK = 2'd0;                             // N+5
    chk("tr_ok", memOutOK, 2'd1);
    chk("tr_oe_off", busOE, 1'b0);
    chk("tr_data", memOutData, 128'h44444444_33333333_22222222_11111111);
    step();                                           // N+6
    chk("tr_ready", memOutOK, 2'd0);
    chk("tr_hold_data", memOutData, 128'h44444444_33333333_22222222_11111111);
    step();

    // tile write, 2 HOLD cycles on beat 2
    req(32'h0000_2000, 128'hDDDDDDDD_CCCCCCCC_BBBBBBBB_AAAAAAAA, 1'b0, 1'b1, 5'd1);
    step(); drop();                                   // N+1
    chk("tw_wr1", busWR, 1'b1);
    chk("tw_oe", busOE, 1'b0);
    chk("tw_d0", busDataOut, 32'hAAAA_AAAA);
    busOK = 2'd1;
    step(); chk("tw_d1", busDataOut, 32'hBBBB_BBBB); chk("tw_a1", busAddr, 32'h2004);
    busOK = 2'd1;
    step(); chk("tw_d2", busDataOut, 32'hCCCC_CCCC); busOK = 2'd2;
    step(); chk("tw_d2h", busDataOut, 32'hCCCC_CCCC); chk("tw_wr4", busWR, 1'b1);
    chk("tw_hold", memOutOK, 2'd2); busOK = 2'd2;
    step(); chk("tw_d2h2", busDataOut, 32'hCCCC_CCCC); chk("tw_a2", busAddr, 32'h2008);
    busOK = 2'd1;
    step(); chk("tw_d3", busDataOut, 32'hDDDD_DDDD); chk("tw_a3", busAddr, 32'h200C);
    chk("tw_wr6", busWR, 1'b1); busOK = 2'd1;
    step(); busOK = 2'd0;                             // N+7
    chk("tw_ok", memOutOK, 2'd1);
    chk("tw_wr_off", busWR, 1'b0);
    chk("tw_data", memOutData, 128'hDDDDDDDD_CCCCCCCC_BBBBBBBB_AAAAAAAA);
    step(); step();

    // DWORD read; an illegal request held during RESP/COOL must wait for IDLE
    req(32'h0000_0107, '0, 1'b1, 1'b0, 5'd2);
    step(); drop();                                   // N+1
    chk("dr_addr", busAddr, 32'h0104);
    chk("dr_oe", busOE, 1'b1);
    busOK = 2'd1; busDataIn = 32'hCAFE_F00D;
    step(); busOK = 2'd0;                             // N+2
    chk("dr_ok", memOutOK, 2'd1);
    chk("dr_data", memOutData, {96'd0, 32'hCAFE_F00D});
    req(32'h0000_0500, '0, 1'b1, 1'b0, 5'd3);
    step(); chk("cool_ready", memOutOK, 2'd0);        // N+3 COOL
    step(); chk("idle_ready", memOutOK, 2'd0);        // N+4 IDLE, accepted at end
    step(); drop();                                   // N+5
    chk("ill_fault", memOutOK, 2'd3);
    chk("ill_oe", busOE, 1'b0);
    chk("ill_wr", busWR, 1'b0);
    step(); chk("ill_cool", memOutOK, 2'd0);
    step();

    // timeout (TIMEOUT=4), bus alternates READY/HOLD and never gives OK
    req(32'h0000_0040, '0, 1'b1, 1'b0, 5'd2);
    step(); drop(); busOK = 2'd0;                     // N+1
    step(); busOK = 2'd2;                             // N+2
    step(); busOK = 2'd0;                             // N+3
    step(); busOK = 2'd2;                             // N+4
    chk("to_hold", memOutOK, 2'd2);
    chk("to_oe_on", busOE, 1'b1);
    step(); busOK = 2'd0;                             // N+5
    chk("to_fault", memOutOK, 2'd3);
    chk("to_oe_off", busOE, 1'b0);
    step(); chk("to_cool", memOutOK, 2'd0);
    step();

    // bus FAULT on tile beat 1
    req(32'h0000_0800, '0, 1'b1, 1'b0, 5'd1);
    step(); drop(); busOK = 2'd1; busDataIn = 32'h1;  // N+1
    step(); chk("bf_a1", busAddr, 32'h0804); busOK = 2'd3;
    step(); busOK = 2'd0;                             // N+3
    chk("bf_fault", memOutOK, 2'd3);
    chk("bf_oe", busOE, 1'b0);
    step(); chk("bf_cool", memOutOK, 2'd0); chk("bf_oe2", busOE, 1'b0);
    step(); chk("bf_oe3", busOE, 1'b0);

    // reset during beat 2
    req(32'h0000_3000, '0, 1'b1, 1'b0, 5'd1);
    step(); drop(); busOK = 2'd1; busDataIn = 32'h7;  // N+1
    step(); busOK = 2'd1;                             // N+2
    step(); busOK = 2'd2;                             // N+3 beat 2
    chk("rm_oe_pre", busOE, 1'b1);
    #2 reset = 1'b0;
    #1;
    chk("rm_oe", busOE, 1'b0);
    chk("rm_ok", memOutOK, 2'd0);
    chk("rm_addr", busAddr, 32'd0);
    chk("rm_data", memOutData, 128'd0);
    step(); chk("rm_ok2", memOutOK, 2'd0);
    reset = 1'b1; busOK = 2'd0;
    step();

    // DWORD write with both strobes set: WR wins
    req(32'h0000_0023, {96'd0, 32'h55AA_55AA}, 1'b1, 1'b1, 5'd2);
    step(); drop();                                   // N+1
    chk("dw_wr", busWR, 1'b1);
    chk("dw_oe", busOE, 1'b0);
    chk("dw_addr", busAddr, 32'h0020);
    chk("dw_dout", busDataOut, 32'h55AA_55AA);
    busOK = 2'd1;
    step(); busOK = 2'd0;                             // N+2
    chk("dw_ok", memOutOK, 2'd1);
    chk("dw_data", memOutData, {96'd0, 32'h55AA_55AA});
    step(); chk("dw_cool", memOutOK, 2'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
